// File: rtl/scan_chain_loader.sv
// scan_chain_loader: loads the memory bank scan chain (memory cells, button,
// LED, locking key) from a byte-wide valid/ready host stream, MSB first, one
// bit per scan_enable cycle, while holding the CPU off the bank.
// Optional feature macro: SCAN_READBACK_EN -- captures the bits leaving the
// chain on scan_out and returns them as bytes on rd_data/rd_valid.
module scan_chain_loader #(
   parameter int CHAIN_LEN = 144,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       scan_enable,
   output logic       scan_in,
   input  logic       scan_out,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

   logic [1:0]       state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             scan_in_d;
   logic             byte_end_s;
   logic             byte_ready_q, scan_enable_q, scan_in_q;
   logic             cpu_hold_q, busy_q, done_q;

   // The 8th shift of a byte is the one where the low three counter bits are all ones.
   assign byte_end_s = (state_q == S_SHIFT) && (bit_cnt_q[2:0] == 3'b111);

   // Next-state, shift register, bit counter and next scan_in bit.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      scan_in_d = 1'b0;
      if (abort) begin
         // Abort leaves the partially shifted chain as it is.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d   = S_WAIT;
                  bit_cnt_d = {CNT_W{1'b0}};
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT: begin
               if (byte_valid && byte_ready_q) begin
                  shreg_d   = byte_in;
                  scan_in_d = byte_in[7];
                  state_d   = S_SHIFT;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_SHIFT: begin
               shreg_d   = {shreg_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (byte_end_s) begin
                  // Counter stops exactly at CHAIN_LEN; it is cleared again on start.
                  state_d = (bit_cnt_d == LAST_CNT) ? S_DONE : S_WAIT;
               end else begin
                  state_d   = S_SHIFT;
                  scan_in_d = shreg_q[6];
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         shreg_q       <= 8'h00;
         bit_cnt_q     <= {CNT_W{1'b0}};
         byte_ready_q  <= 1'b0;
         scan_enable_q <= 1'b0;
         scan_in_q     <= 1'b0;
         cpu_hold_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_ready_q  <= (state_d == S_WAIT);
         scan_enable_q <= (state_d == S_SHIFT);
         scan_in_q     <= scan_in_d;
         cpu_hold_q    <= (state_d != S_IDLE);
         busy_q        <= (state_d != S_IDLE);
         done_q        <= (state_d == S_DONE);
      end
   end

   assign byte_ready  = byte_ready_q;
   assign scan_enable = scan_enable_q;
   assign scan_in     = scan_in_q;
   assign cpu_hold    = cpu_hold_q;
   assign busy        = busy_q;
   assign done        = done_q;

`ifdef SCAN_READBACK_EN
   logic [7:0] cap_q, cap_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;

   // Capture the bit leaving the chain on every shift; present a byte after its 8th bit.
   always_comb begin
      cap_d      = cap_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if ((state_q == S_SHIFT) && !abort) begin
         cap_d = {cap_q[6:0], scan_out};
         if (byte_end_s) begin
            rd_data_d  = {cap_q[6:0], scan_out};
            rd_valid_d = 1'b1;
         end else begin
            rd_valid_d = 1'b0;
         end
      end else begin
         cap_d = cap_q;
      end
   end

   // Readback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q      <= 8'h00;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         cap_q      <= cap_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`else
   logic unused_scan_out_s;

   assign unused_scan_out_s = scan_out;
   assign rd_data           = 8'h00;
   assign rd_valid          = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed self-checking bench for scan_chain_loader. A 144-bit chain model
// sits on scan_in/scan_out. Cycle 1 is the cycle in which start is driven.
module tb_scan_chain_loader;

   logic       clk = 1'b0;
   logic       rst, start, abort, byte_valid, scan_out;
   logic [7:0] byte_in;
   logic       byte_ready, scan_enable, scan_in, cpu_hold, busy, done, rd_valid;
   logic [7:0] rd_data;

   int n_checks = 0;
   int n_err    = 0;

   // Run observations.
   logic       bits_q[$];
   logic [7:0] rd_q[$];
   int         done_cnt, done_cyc, hold_low, hold_bad, overlap, post_act;
   logic       hold_after;

   logic [143:0] chain = '0;

   always #5 clk = ~clk;

   // Memory bank scan chain model.
   always @(posedge clk) if (scan_enable) chain <= {chain[142:0], scan_in};
   assign scan_out = chain[143];

   scan_chain_loader #(.CHAIN_LEN(144), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .rd_data(rd_data), .rd_valid(rd_valid)
   );

   function automatic logic [7:0] get_byte(input int k);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[7-j] = bits_q[8*k+j];
      return b;
   endfunction

   // Drive one load from cycle 1 to max_cyc; host byte k is k ^ mask. Entered and left at a negedge.
   task automatic run_load(input int nbytes, input int gap_idx, input int gap_len,
                           input int abort_cyc, input int rst_cyc, input int restart_cyc,
                           input int max_cyc, input logic [7:0] mask);
      int idx, gap_done, ev;
      logic fire, seen_end;
      bits_q.delete(); rd_q.delete();
      done_cnt = 0; done_cyc = 0; hold_low = 0; hold_bad = 0; overlap = 0; post_act = 0;
      hold_after = 1'b1; seen_end = 1'b0;
      ev = (abort_cyc > 0) ? abort_cyc : rst_cyc;
      idx = 0; gap_done = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         if (c > 1) begin
            if (scan_enable) bits_q.push_back(scan_in);
            if (scan_enable && byte_ready) overlap++;
            if (cpu_hold !== busy) hold_bad++;
            if (!seen_end && cpu_hold !== 1'b1) hold_low++;
            if (done_cyc > 0 && c == done_cyc + 1) hold_after = cpu_hold;
            if (done) begin done_cnt++; done_cyc = c; seen_end = 1'b1; end
            if (ev > 0 && c > ev && (scan_enable || busy || byte_ready || cpu_hold || done || rd_valid))
               post_act++;
            if (rd_valid) rd_q.push_back(rd_data);
         end
         start = (c == 1) || (c == restart_cyc);
         abort = (c == abort_cyc);
         rst   = (c == rst_cyc);
         if (idx == gap_idx && gap_done < gap_len) begin
            byte_valid = 1'b0;
            if (byte_ready) gap_done++;
         end else begin
            byte_valid = (idx < nbytes);
            byte_in    = idx[7:0] ^ mask;
         end
         fire = byte_valid && byte_ready && !abort && !rst;
         @(posedge clk);
         if (fire) idx++;
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; rst = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({byte_ready, scan_enable, scan_in, cpu_hold, busy, done, rd_valid} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b expected 0000000",
                           {byte_ready, scan_enable, scan_in, cpu_hold, busy, done, rd_valid});
      end
      n_checks++;
      if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_full_load();
      run_load(18, -1, 0, 0, 0, 0, 170, 8'h00);
      n_checks++;
      if (bits_q.size() != 144) begin n_err++; $display("FAIL full_bits: got %0d expected 144", bits_q.size()); end
      for (int k = 0; k < 18 && bits_q.size() == 144; k++) begin
         n_checks++;
         if (get_byte(k) !== k[7:0]) begin
            n_err++; $display("FAIL full_byte%0d: got %h expected %h", k, get_byte(k), k[7:0]);
         end
      end
      n_checks++;
      if (done_cnt != 1) begin n_err++; $display("FAIL full_done_cnt: got %0d expected 1", done_cnt); end
      n_checks++;
      if (done_cyc != 164) begin n_err++; $display("FAIL full_done_cyc: got %0d expected 164", done_cyc); end
      n_checks++;
      if (hold_low != 0) begin n_err++; $display("FAIL full_hold_low: got %0d expected 0", hold_low); end
      n_checks++;
      if (hold_after !== 1'b0) begin n_err++; $display("FAIL full_hold_after: got %b expected 0", hold_after); end
      n_checks++;
      if (hold_bad != 0) begin n_err++; $display("FAIL full_hold_eq_busy: got %0d expected 0", hold_bad); end
      n_checks++;
      if (overlap != 0) begin n_err++; $display("FAIL full_overlap: got %0d expected 0", overlap); end
`ifndef SCAN_READBACK_EN
      n_checks++;
      if (rd_q.size() != 0 || rd_data !== 8'h00) begin
         n_err++; $display("FAIL readback_off: got %0d pulses data %h expected 0 pulses data 00", rd_q.size(), rd_data);
      end
`endif
   endtask

   task automatic test_stall();
      run_load(18, 3, 5, 0, 0, 0, 175, 8'h00);
      n_checks++;
      if (bits_q.size() != 144) begin n_err++; $display("FAIL stall_bits: got %0d expected 144", bits_q.size()); end
      for (int k = 0; k < 18 && bits_q.size() == 144; k++) begin
         n_checks++;
         if (get_byte(k) !== k[7:0]) begin
            n_err++; $display("FAIL stall_byte%0d: got %h expected %h", k, get_byte(k), k[7:0]);
         end
      end
      n_checks++;
      if (done_cyc != 169) begin n_err++; $display("FAIL stall_done_cyc: got %0d expected 169", done_cyc); end
      n_checks++;
      if (overlap != 0) begin n_err++; $display("FAIL stall_overlap: got %0d expected 0", overlap); end
   endtask

   task automatic test_abort();
      // Byte 7 shifts in cycles 66..73; abort in its 4th shift cycle.
      run_load(18, -1, 0, 69, 0, 0, 90, 8'h00);
      n_checks++;
      if (bits_q.size() != 60) begin n_err++; $display("FAIL abort_bits: got %0d expected 60", bits_q.size()); end
      n_checks++;
      if (done_cnt != 0) begin n_err++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
      n_checks++;
      if (post_act != 0) begin n_err++; $display("FAIL abort_post_activity: got %0d expected 0", post_act); end
   endtask

   task automatic test_start_ignored();
      // Cycle 23 is a shift cycle of byte 2.
      run_load(18, -1, 0, 0, 0, 23, 170, 8'h00);
      n_checks++;
      if (done_cnt != 1 || done_cyc != 164) begin
         n_err++; $display("FAIL start_mid_shift: got %0d pulses at %0d expected 1 at 164", done_cnt, done_cyc);
      end
      n_checks++;
      if (bits_q.size() != 144) begin n_err++; $display("FAIL start_mid_bits: got %0d expected 144", bits_q.size()); end
      run_load(18, -1, 0, 0, 0, 0, 170, 8'h3C);
      n_checks++;
      if (done_cnt != 1 || done_cyc != 164) begin
         n_err++; $display("FAIL restart_done: got %0d pulses at %0d expected 1 at 164", done_cnt, done_cyc);
      end
      n_checks++;
      if (bits_q.size() == 144 ? get_byte(0) !== 8'h3C : 1'b1) begin
         n_err++; $display("FAIL restart_byte0: got %0d bits expected 144 bits starting 3c", bits_q.size());
      end
   endtask

   task automatic test_rst_mid();
      // Cycle 11 is the wait for byte 1 with the host already offering it.
      run_load(18, -1, 0, 0, 11, 0, 20, 8'h00);
      n_checks++;
      if (post_act != 0) begin n_err++; $display("FAIL rst_post_activity: got %0d expected 0", post_act); end
      n_checks++;
      if (bits_q.size() != 8) begin n_err++; $display("FAIL rst_bits: got %0d expected 8", bits_q.size()); end
      n_checks++;
      if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h expected 00", rd_data); end
   endtask

`ifdef SCAN_READBACK_EN
   task automatic test_readback();
      run_load(18, -1, 0, 0, 0, 0, 170, 8'h00);
      run_load(18, -1, 0, 0, 0, 0, 170, 8'hA5);
      n_checks++;
      if (rd_q.size() != 18) begin n_err++; $display("FAIL rb_count: got %0d expected 18", rd_q.size()); end
      for (int k = 0; k < 18 && rd_q.size() == 18; k++) begin
         n_checks++;
         if (rd_q[k] !== k[7:0]) begin
            n_err++; $display("FAIL rb_byte%0d: got %h expected %h", k, rd_q[k], k[7:0]);
         end
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_full_load();
      test_stall();
      test_abort();
      test_start_ignored();
      test_rst_mid();
`ifdef SCAN_READBACK_EN
      test_readback();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
